// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs, states, mux selects.
// No logic here; constants and types only.
// No flow control; consumers are purely combinational or the state register.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_BEQ  = 4'd8,
        S_J    = 4'd9,
        S_AEX  = 4'd10,
        S_AWB  = 4'd11,
        S_JAL  = 4'd12,
        S_JR   = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic       IORD_PC     = 1'b0;
    localparam logic       IORD_ALUOUT = 1'b1;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] M2R_ALUOUT = 2'd0;
    localparam logic [1:0] M2R_MDR    = 2'd1;
    localparam logic [1:0] M2R_PC     = 2'd2;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_REG    = 2'd3;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Maps the controller's 2-bit alu_op plus funct to the 3-bit ALU operation.
// Combinational, zero latency.
// No flow control.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    // unrecognised functs fall back to add so the datapath stays benign
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore control FSM for the multi-cycle MIPS core; drives every datapath select and enable.
// Outputs are combinational from state (plus zero/funct); 2-5 cycles per instruction.
// No backpressure: the datapath and memory are assumed single-cycle.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctrl
);

    state_t  state;
    state_t  next_state;
    alu_op_t alu_op;
    logic    pc_write;
    logic    pc_write_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = S_IF;
        case (state)
            S_IF: next_state = S_ID;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = S_MADR;
                    OP_RTYPE:     next_state = (funct == FN_JR) ? S_JR : S_REX;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_ADDI:      next_state = S_AEX;
                    OP_J:         next_state = S_J;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_IF;
                endcase
            end
            S_MADR:  next_state = (opcode == OP_SW) ? S_MWR : S_MRD;
            S_MRD:   next_state = S_MWB;
            S_REX:   next_state = S_RWB;
            S_AEX:   next_state = S_AWB;
            default: next_state = S_IF;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = IORD_PC;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = M2R_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_B;
        pc_src        = PCSRC_ALU;
        alu_op        = ALUOP_ADD;
        case (state)
            S_IF: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                pc_src    = PCSRC_ALU;
            end
            // branch target is computed speculatively into ALUOut here
            S_ID: alu_src_b = SRCB_IMM_SH;
            S_MADR, S_AEX: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_IMM;
            end
            S_MRD: begin
                i_or_d   = IORD_ALUOUT;
                mem_read = 1'b1;
            end
            S_MWB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = M2R_MDR;
            end
            S_MWR: begin
                i_or_d    = IORD_ALUOUT;
                mem_write = 1'b1;
            end
            S_REX: begin
                alu_src_a = SRCA_A;
                alu_src_b = SRCB_B;
                alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = M2R_ALUOUT;
            end
            S_BEQ: begin
                alu_src_a     = SRCA_A;
                alu_src_b     = SRCB_B;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
            end
            S_J: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
            end
            // PC already holds PC+4 here, which is the link value
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = PCSRC_JUMP;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_REG;
            end
            S_AWB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = M2R_ALUOUT;
            end
            default: ;
        endcase
        // reset must quiesce the datapath without waiting for the async state update to settle
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            i_or_d        = IORD_PC;
            reg_dst       = REGDST_RT;
            mem_to_reg    = M2R_ALUOUT;
            alu_src_a     = SRCA_PC;
            alu_src_b     = SRCB_B;
            pc_src        = PCSRC_ALU;
            alu_op        = ALUOP_ADD;
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle MIPS control unit. It is a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. Each cycle it drives the datapath's 2:1 and 4:1 mux selects and the register, memory and PC write enables. It sits beside the datapath, takes the instruction register's opcode/funct fields and the ALU zero flag, and is the sole source of every mux select in the core.

## Interface
- No parameters. Widths are fixed by the MIPS ISA.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `opcode` in 6: IR[31:26].
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `pc_en` out 1: PC load enable.
- `i_or_d` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write` out 1 each: memory strobes.
- `ir_write` out 1: IR load enable.
- `reg_write` out 1: register-file write enable.
- `reg_dst` out 2: write register select. 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg` out 2: write data select. 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` out 1: ALU A select. 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU B select. 0 = B register, 1 = 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `pc_src` out 2: next-PC select. 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], IR[25:0], 2'b00}, 3 = A register.
- `alu_ctrl` out 3: ALU operation. 010 add, 110 sub, 000 and, 001 or, 111 slt.

## Operation
- Supported opcodes:
  - R-type 000000; funct add 100000, sub 100010, and 100100, or 100101, slt 101010, jr 001000.
  - lw 100011, sw 101011, beq 000100, addi 001000, j 000010, jal 000011.
- The state register holds one of 14 states, encoded 0–13: IF, ID, MADR, MRD, MWB, MWR, REX, RWB, BEQ, J, AEX, AWB, JAL, JR.
- Transitions and asserted outputs. Any output not listed is 0; selects not listed are don't-care but are driven 0.
  - IF: `mem_read`, `ir_write`, `alu_src_b`=1, `pc_write`, `pc_src`=0. Goes to ID.
  - ID: `alu_src_b`=3, `alu_op`=add, which computes the branch target into ALUOut. Next state by opcode:
    - lw/sw → MADR
    - R-type with funct jr → JR; any other R-type → REX
    - beq → BEQ
    - addi → AEX
    - j → J
    - jal → JAL
    - any other opcode → IF (treated as NOP)
  - MADR: `alu_src_a`=1, `alu_src_b`=2, add. Goes to MRD for lw, MWR for sw.
  - MRD: `i_or_d`, `mem_read`. Goes to MWB.
  - MWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=1. Goes to IF.
  - MWR: `i_or_d`, `mem_write`. Goes to IF.
  - REX: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=funct. Goes to RWB.
  - RWB: `reg_write`, `reg_dst`=1, `mem_to_reg`=0. Goes to IF.
  - BEQ: `alu_src_a`=1, `alu_src_b`=0, sub, `pc_write_cond`, `pc_src`=1. Goes to IF.
  - J: `pc_write`, `pc_src`=2. Goes to IF.
  - JAL: `pc_write`, `pc_src`=2, `reg_write`, `reg_dst`=2, `mem_to_reg`=2. Goes to IF. The register file captures the PC before this edge, which is already PC+4.
  - JR: `pc_write`, `pc_src`=3. Goes to IF.
  - AEX: `alu_src_a`=1, `alu_src_b`=2, add. Goes to AWB.
  - AWB: `reg_write`, `reg_dst`=0, `mem_to_reg`=0. Goes to IF.
- `pc_write` and `pc_write_cond` are internal. `pc_en = pc_write | (pc_write_cond & zero)`.
- `alu_op` is internal, 2 bits: 00 add, 01 sub, 10 decode from funct.
  - Under 10, funct maps per the ISA list above.
  - An unknown funct gives add (010).

## Timing
- The state register updates on the rising edge of `clk`. Outputs are combinational from the state; `pc_en` and `alu_ctrl` also depend combinationally on `zero` and `funct`.
- While `rst` is high, the state is forced to IF asynchronously, and all enables and strobes are forced to 0 (`pc_en`, `ir_write`, `reg_write`, `mem_read`, `mem_write`). Selects are 0 and `alu_ctrl` is 010.
- The first fetch occurs on the first rising edge after `rst` falls.
- Reset mid-instruction abandons the instruction; no partial write-back occurs after reset.
- Cycles per instruction:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw, R-type (non-jr), addi | 4 |
| beq, j, jal, jr | 3 |
| unknown opcode | 2 |

- `zero` is sampled only in BEQ. Toggling `zero` in any other state must not affect `pc_en`.

## Structure
- Package `mc_pkg` holds the opcode and funct constants, the state enumeration, the `alu_op` and `alu_ctrl` encodings, and named constants for every select value listed above.
- Sub-module `alu_decoder`: inputs `alu_op` and `funct`, output `alu_ctrl`. It is purely combinational.
- The top level contains the state register, the next-state logic and the output decode.

## Test plan
- **Reset mid-REX:** assert `rst` while in REX.
  - Required: all enables are 0 immediately, without waiting for a clock edge.
  - After release: first edge gives `mem_read`=`ir_write`=`pc_en`=1 with `alu_src_b`=1.
- **lw** (`opcode`=100011): state sequence IF, ID, MADR, MRD, MWB, IF.
  - Required: in MRD, `i_or_d`=1 and `mem_read`=1.
  - Required: in MWB, `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- **beq** (`opcode`=000100):
  - Run with `zero`=1: required `pc_en`=1 in BEQ with `pc_src`=1.
  - Repeat with `zero`=0: required `pc_en`=0.
  - Required in both runs: the instruction completes in 3 cycles.
- **jal** (`opcode`=000011): required in the JAL cycle `pc_en`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2.
- **R-type:**
  - funct 101010 (slt): required `alu_ctrl`=111 in REX, then `reg_dst`=1 in RWB.
  - funct 001000 (jr): required JR state with `pc_src`=3 and no `reg_write`.
- **Unknown opcode** 111111: required ID goes directly to IF, with no enable asserted in ID. Separately, toggling `zero` during IF must leave `pc_en`=1.
